// File: rtl/rv16_regfile_mp.sv
// Parametrised RV16 register file: two prioritised write ports, two combinational
// read ports and a sequential clear engine. Define RV16_RF_BYPASS_EN for write-to-read forwarding.
module rv16_regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic [4:0]      i_wa_addr,
  input  logic [XLEN-1:0] i_wa_data,
  input  logic            i_wa_en,
  input  logic [4:0]      i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_wb_en,
  input  logic            i_clear_req,
  output logic            o_clear_busy,
  output logic            o_clear_done
);

  localparam int             AW        = (NREGS > 4) ? $clog2(NREGS) : 2;
  localparam logic [AW-1:0]  IDX_FIRST = AW'(1);
  localparam logic [AW-1:0]  IDX_LAST  = AW'(NREGS - 1);
  localparam logic [5:0]     NREGS_EXT = 6'(NREGS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [XLEN-1:0] regs_r [NREGS];
  logic [1:0]      state_r;
  logic [AW-1:0]   idx_r;
  logic            busy_r;
  logic            done_r;

  logic            wa_commit_s;
  logic            wb_commit_s;
  logic            rs1_ok_s;
  logic            rs2_ok_s;
  logic [XLEN-1:0] rs1_arr_s;
  logic [XLEN-1:0] rs2_arr_s;
  logic [XLEN-1:0] rs1_data_s;
  logic [XLEN-1:0] rs2_data_s;

  // x0 and anything beyond the implemented depth are neither writable nor readable
  function automatic logic addr_ok(input logic [4:0] addr);
    logic [5:0] ext;
    ext     = {1'b0, addr};
    addr_ok = (addr != 5'd0) && (ext < NREGS_EXT);
  endfunction

  // Write qualification: clear engine blocks both ports, port A wins on a shared address
  always_comb begin
    wa_commit_s = 1'b0;
    wb_commit_s = 1'b0;
    if (i_wa_en && !busy_r && addr_ok(i_wa_addr)) begin
      wa_commit_s = 1'b1;
    end else begin
      wa_commit_s = 1'b0;
    end
    if (i_wb_en && !busy_r && addr_ok(i_wb_addr) &&
        !(wa_commit_s && (i_wb_addr == i_wa_addr))) begin
      wb_commit_s = 1'b1;
    end else begin
      wb_commit_s = 1'b0;
    end
  end

  // Clear engine sequencing; the index never returns to 0 so x0 is never touched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= IDX_FIRST;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          idx_r  <= IDX_FIRST;
          if (i_clear_req) begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (idx_r == IDX_LAST) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            idx_r   <= idx_r + IDX_FIRST;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          idx_r   <= IDX_FIRST;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= IDX_FIRST;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Register array: clear engine owns the array while busy, otherwise committed writes land
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (busy_r) begin
      regs_r[idx_r] <= '0;
    end else begin
      if (wb_commit_s) begin
        regs_r[i_wb_addr[AW-1:0]] <= i_wb_data;
      end
      if (wa_commit_s) begin
        regs_r[i_wa_addr[AW-1:0]] <= i_wa_data;
      end
    end
  end

  assign rs1_ok_s  = addr_ok(i_rs1_addr);
  assign rs2_ok_s  = addr_ok(i_rs2_addr);
  assign rs1_arr_s = regs_r[i_rs1_addr[AW-1:0]];
  assign rs2_arr_s = regs_r[i_rs2_addr[AW-1:0]];

  // Read port 1 select
  always_comb begin
    rs1_data_s = '0;
    if (!rs1_ok_s) begin
      rs1_data_s = '0;
`ifdef RV16_RF_BYPASS_EN
    end else if (wa_commit_s && (i_wa_addr == i_rs1_addr)) begin
      rs1_data_s = i_wa_data;
    end else if (wb_commit_s && (i_wb_addr == i_rs1_addr)) begin
      rs1_data_s = i_wb_data;
`endif
    end else begin
      rs1_data_s = rs1_arr_s;
    end
  end

  // Read port 2 select
  always_comb begin
    rs2_data_s = '0;
    if (!rs2_ok_s) begin
      rs2_data_s = '0;
`ifdef RV16_RF_BYPASS_EN
    end else if (wa_commit_s && (i_wa_addr == i_rs2_addr)) begin
      rs2_data_s = i_wa_data;
    end else if (wb_commit_s && (i_wb_addr == i_rs2_addr)) begin
      rs2_data_s = i_wb_data;
`endif
    end else begin
      rs2_data_s = rs2_arr_s;
    end
  end

  assign o_rs1_data   = rs1_data_s;
  assign o_rs2_data   = rs2_data_s;
  assign o_clear_busy = busy_r;
  assign o_clear_done = done_r;

endmodule

// File: tb/tb_rv16_regfile_mp.sv
// Randomised bench for rv16_regfile_mp against a timestamp-based reference model,
// plus directed checks on a small NREGS=8 / XLEN=16 instance.
module tb_rv16_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [4:0]  rs1_addr, rs2_addr, wa_addr, wb_addr;
  logic [31:0] rs1_data, rs2_data, wa_data, wb_data;
  logic        wa_en, wb_en, clear_req, clear_busy, clear_done;

  logic [4:0]  s_rs1_addr, s_rs2_addr, s_wa_addr, s_wb_addr;
  logic [15:0] s_rs1_data, s_rs2_data, s_wa_data, s_wb_data;
  logic        s_wa_en, s_wb_en, s_clear_req, s_clear_busy, s_clear_done;

  rv16_regfile_mp #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
    .i_wa_addr(wa_addr), .i_wa_data(wa_data), .i_wa_en(wa_en),
    .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_en(wb_en),
    .i_clear_req(clear_req), .o_clear_busy(clear_busy), .o_clear_done(clear_done)
  );

  rv16_regfile_mp #(.XLEN(16), .NREGS(8)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .i_rs1_addr(s_rs1_addr), .i_rs2_addr(s_rs2_addr),
    .o_rs1_data(s_rs1_data), .o_rs2_data(s_rs2_data),
    .i_wa_addr(s_wa_addr), .i_wa_data(s_wa_data), .i_wa_en(s_wa_en),
    .i_wb_addr(s_wb_addr), .i_wb_data(s_wb_data), .i_wb_en(s_wb_en),
    .i_clear_req(s_clear_req), .o_clear_busy(s_clear_busy), .o_clear_done(s_clear_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: contents plus the edge number at which the last clear was accepted.
  // Edge c+k (k=1..31) zeroes x[k]; busy after edges c..c+30, done after edge c+31.
  logic [31:0] mdl [32];
  int edge_n   = 0;
  int clr_edge = -1;

  function automatic int age(input int e);
    return (clr_edge < 0) ? -1 : (e - clr_edge);
  endfunction

  function automatic bit wr_blocked(input int e);
    int k;
    k = age(e);
    return (k >= 1) && (k <= 31);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef RV16_RF_BYPASS_EN
    if (!wr_blocked(edge_n + 1)) begin
      if (wa_en && wa_addr == a) return wa_data;
      if (wb_en && wb_addr == a) return wb_data;
    end
`endif
    return mdl[a];
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    clr_edge = -1;
  endtask

  task automatic model_edge();
    int k;
    edge_n++;
    k = age(edge_n);
    if (wr_blocked(edge_n)) begin
      mdl[k] = 32'd0;
    end else begin
      if (wb_en && wb_addr != 5'd0) mdl[wb_addr] = wb_data;
      if (wa_en && wa_addr != 5'd0) mdl[wa_addr] = wa_data;
    end
    if (clear_req && !(k >= 1 && k <= 32)) clr_edge = edge_n;
  endtask

  task automatic step();
    int k;
    #1;
    check_val("rd_rs1", rs1_data, exp_read(rs1_addr));
    check_val("rd_rs2", rs2_data, exp_read(rs2_addr));
    @(posedge clk);
    model_edge();
    #1;
    k = age(edge_n);
    check_val("busy", clear_busy, (k >= 0 && k <= 30) ? 1 : 0);
    check_val("done", clear_done, (k == 31) ? 1 : 0);
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; clear_req = 1'b0;
    wa_addr = 5'd0; wb_addr = 5'd0; wa_data = 32'd0; wb_data = 32'd0;
  endtask

  int busy_n, done_n, n;

  initial begin
    rst_n = 1'b0;
    idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    s_rs1_addr = 5'd0; s_rs2_addr = 5'd0; s_wa_addr = 5'd0; s_wb_addr = 5'd0;
    s_wa_data = 16'd0; s_wb_data = 16'd0; s_wa_en = 1'b0; s_wb_en = 1'b0; s_clear_req = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_val("rst_busy", clear_busy, 0);
    check_val("rst_done", clear_done, 0);
    check_val("rst_s_busy", s_clear_busy, 0);
    check_val("rst_s_done", s_clear_done, 0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      #1;
      check_val("rst_rs1", rs1_data, 0);
      check_val("rst_rs2", rs2_data, 0);
    end
    @(posedge clk); #1;

    // Small instance: out-of-range write, in-range write, 7-cycle clear
    s_wa_addr = 5'd9; s_wa_data = 16'hBEEF; s_wa_en = 1'b1;
    @(posedge clk); #1;
    s_wa_en = 1'b0; s_rs1_addr = 5'd9; s_rs2_addr = 5'd1;
    #1;
    check_val("s_oor_rd", s_rs1_data, 0);
    check_val("s_alias_rd", s_rs2_data, 0);
    s_wa_addr = 5'd7; s_wa_data = 16'h1234; s_wa_en = 1'b1;
    @(posedge clk); #1;
    s_wa_en = 1'b0; s_rs1_addr = 5'd7;
    #1;
    check_val("s_x7", s_rs1_data, 16'h1234);
    s_clear_req = 1'b1;
    @(posedge clk); #1;
    s_clear_req = 1'b0;
    n = 0;
    while (s_clear_busy && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check_val("s_busy_len", n, 7);
    check_val("s_done_pulse", s_clear_done, 1);
    check_val("s_x7_clr", s_rs1_data, 0);
    @(posedge clk); #1;
    check_val("s_done_end", s_clear_done, 0);

    // Same-address conflict, x0 write, forwarding
    wa_addr = 5'd5; wa_data = 32'hDEADBEEF; wa_en = 1'b1;
    wb_addr = 5'd5; wb_data = 32'h12345678; wb_en = 1'b1;
    rs1_addr = 5'd5;
    step();
    idle();
    #1;
    check_val("ab_prio", rs1_data, 32'hDEADBEEF);
    wa_addr = 5'd0; wa_data = 32'hFFFFFFFF; wa_en = 1'b1; rs2_addr = 5'd0;
    step();
    idle();
    #1;
    check_val("x0_ro", rs2_data, 0);
    rs1_addr = 5'd7; wa_addr = 5'd7; wa_data = 32'hA5A5A5A5; wa_en = 1'b1;
    #1;
`ifdef RV16_RF_BYPASS_EN
    check_val("bypass", rs1_data, 32'hA5A5A5A5);
`else
    check_val("bypass", rs1_data, 0);
`endif
    step();
    idle();
    #1;
    check_val("x7_after", rs1_data, 32'hA5A5A5A5);

    // Load x1..x31 with their index, then clear with a dropped write during busy
    for (int i = 1; i < 32; i++) begin
      wa_addr = 5'(i); wa_data = 32'(i); wa_en = 1'b1;
      rs1_addr = 5'(i); rs2_addr = 5'(i - 1);
      step();
    end
    idle();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    busy_n = clear_busy ? 1 : 0;
    done_n = 0;
    rs1_addr = 5'd3; rs2_addr = 5'd31;
    for (int t = 0; t < 36; t++) begin
      if (t == 4) begin
        wa_addr = 5'd3; wa_data = 32'h55; wa_en = 1'b1;
      end else begin
        wa_en = 1'b0;
      end
      step();
      busy_n += clear_busy ? 1 : 0;
      done_n += clear_done ? 1 : 0;
    end
    check_val("busy_len", busy_n, 31);
    check_val("done_len", done_n, 1);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(a);
      #1;
      check_val("post_clear", rs1_data, 0);
      step();
    end

    // Random traffic with occasional clears
    for (int it = 0; it < 500; it++) begin
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 3) == 0) ? wa_addr : 5'($urandom_range(0, 31));
      wa_en = 1'($urandom_range(0, 1));
      wb_en = 1'($urandom_range(0, 1));
      wa_addr = 5'($urandom_range(0, 7));
      wb_addr = ($urandom_range(0, 2) == 0) ? wa_addr : 5'($urandom_range(0, 31));
      wa_data = $urandom;
      wb_data = $urandom;
      if ($urandom_range(0, 3) == 0) rs1_addr = wa_addr;
      clear_req = ($urandom_range(0, 59) == 0);
      step();
    end
    idle();
    repeat (40) step();

    // Reset in the middle of a clear
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (9) step();
    check_val("mid_busy_pre", clear_busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", clear_busy, 0);
    check_val("mid_rst_done", clear_done, 0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      #1;
      check_val("mid_rst_rd", rs1_data, 0);
    end
    mdl_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    n = 1;
    while (!clear_done && n < 40) begin
      step();
      n++;
    end
    check_val("clr_latency", n, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv16_regfile_mp.md
# rv16_regfile_mp

Parametrised register file for the RV16 core, replacing the fixed 32 x 32-bit, single-write-port register file. It adds configurable width and depth, a second write port with fixed priority, optional write-to-read forwarding, and a sequential clear engine for context flush. It sits between decode (read ports) and writeback (write ports). Read data is combinational; all state changes are synchronous.

## Interface
- XLEN, 32: data width in bits (8..64).
- NREGS, 32: number of registers, power of two (4..32). AW = $clog2(NREGS), minimum 2.
- clk  in  1  clock; all state updates occur on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_rs1_addr, i_rs2_addr  in  5  read addresses.
- o_rs1_data, o_rs2_data  out  XLEN  combinational read data.
- i_wa_addr  in  5; i_wa_data  in  XLEN; i_wa_en  in  1: write port A (high priority).
- i_wb_addr  in  5; i_wb_data  in  XLEN; i_wb_en  in  1: write port B (low priority).
- i_clear_req  in  1  request a full register clear.
- o_clear_busy  out  1  clear engine active; all writes are dropped while high.
- o_clear_done  out  1  one-cycle pulse when the clear completes.

## Operation
- Register 0 is hardwired to zero. Writes to address 0 are ignored and reads of address 0 return 0.
- Addresses >= NREGS: writes are ignored and reads return 0.
- Write port A commits when i_wa_en=1 and the clear engine is not busy. Port B follows the same rule.
- When both ports write the same valid address in one cycle, port A's data is stored and port B's write is discarded.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when i_clear_req=1. The index counter loads 1.
  - In CLEAR, each cycle zeroes reg[idx], then idx increments. After reg[NREGS-1] is zeroed, the FSM moves to DONE.
  - DONE -> IDLE unconditionally after one cycle.
- i_clear_req is ignored in CLEAR and DONE; it is not queued.
- A write presented in IDLE on the same edge that i_clear_req is sampled commits, and the clear engine later zeroes it.
- In DONE, writes are accepted normally.
- Reads are always permitted. During CLEAR they return current contents, so registers already cleared read 0 and registers not yet reached keep their old values.

## Timing
- Reset, asynchronous: all registers = 0, FSM = IDLE, idx = 1, o_clear_busy = 0, o_clear_done = 0. Read outputs therefore read 0.
- Write latency: data is stored at the edge where the enable is sampled and is visible on the read ports in the following cycle. With bypass enabled, it is visible in the same cycle.
- o_clear_busy = (state == CLEAR). It goes high the cycle after i_clear_req is sampled and stays high for exactly NREGS-1 cycles.
- o_clear_done = (state == DONE): a single-cycle pulse immediately after busy falls.
- Total request-to-done latency is NREGS cycles.
- Reset asserted mid-clear: the FSM returns immediately to IDLE, all registers read 0, and no done pulse is produced.
- The idx counter is AW bits wide. The terminal compare is against NREGS-1, so the counter never wraps into register 0.

## Configuration
- RV16_RF_BYPASS_EN defined:
  - A read address equal to a committing write address returns that write data combinationally in the same cycle.
  - Port A is checked first, then port B, then the array.
  - Address 0, out-of-range addresses and writes dropped during CLEAR are never forwarded.
- RV16_RF_BYPASS_EN undefined: reads return array contents only, i.e. pre-write data in the write cycle.

## Test plan
- Reset, then read all addresses 0..31 with NREGS=32 -> all o_rs*_data = 0; o_clear_busy = 0; o_clear_done = 0.
- Port A writes 0xDEADBEEF to x5 and port B writes 0x12345678 to x5 in the same cycle -> next cycle rs1=x5 reads 0xDEADBEEF. Port A writing 0xFFFFFFFF to x0 -> rs2=x0 reads 0.
- Bypass: port A writes 0xA5A5A5A5 to x7 with rs1=x7 in the same cycle -> reads 0xA5A5A5A5 with RV16_RF_BYPASS_EN defined; reads the old value 0 without it.
- Load x1..x31 with their own index, then pulse i_clear_req:
  - o_clear_busy is high for 31 cycles, then o_clear_done pulses for 1 cycle.
  - A port A write of 0x55 to x3 during busy is dropped.
  - Afterwards all registers read 0.
- NREGS=8, XLEN=16:
  - Write 0xBEEF to x9 -> ignored, reads 0.
  - Write 0x1234 to x7 -> reads 0x1234.
  - Clear -> busy lasts 7 cycles.
- Assert rst_n low at cycle 10 of a clear with NREGS=32 -> busy drops immediately, no done pulse, all registers read 0. A new clear after reset completes in 32 cycles.
